// File: rtl/dlfloat_vmac.sv
// dlfloat_vmac - streaming DLfloat16 dot-product engine.
//
// Takes operand pairs over a valid/ready handshake. It multiplies each pair
// and accumulates up to VEC_LEN products, or fewer when in_last_i is set. It
// then presents the sum on a valid/ready output port and clears itself for
// the next vector.
//
// DLfloat16: s[15], e[14:9] (bias 31), m[8:0] with a hidden leading one.
// e==0 is zero. Any e==63 is special, and the special result code is 0xFFFF.
//
// Optional build macro:
//   DLMAC_ROUND_EN  multiplier rounds to nearest, ties to even
//                   (default: truncation, bit-exact with the single-pair MAC)
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   engine accepts a pair (ACCUM only)
//   in_a_i       DLfloat16 operand A
//   in_b_i       DLfloat16 operand B
//   in_last_i    this pair ends the vector early
//   out_valid_o  result valid (OUT only)
//   out_ready_i  downstream accepts the result
//   out_data_o   DLfloat16 dot product
//   out_count_o  number of products accumulated into out_data_o
//   busy_o       high in any state except ACCUM with a beat count of 0
//
// State table:
//   state    | meaning
//   ST_ACCUM | accept beats; each beat's product is added one cycle later
//   ST_DRAIN | final product is added into the accumulator
//   ST_OUT   | load result, hold it until the output transfer, then clear

module dlfloat_vmac #(
    parameter int VEC_LEN = 8,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_a_i,
    input  logic [15:0]      in_b_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [15:0]      out_data_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      prod_q, prod_d;
    logic             prod_v_q, prod_v_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    logic [15:0] mul_res;
    logic [9:0]  mul_ma, mul_mb;
    logic        mul_norm;
    logic [8:0]  mul_man;
    logic [8:0]  mul_exp_sum;   // ea + eb + norm, still carrying two biases
    logic        mul_spec, mul_zero;
`ifdef DLMAC_ROUND_EN
    logic [19:0] mul_prod;
    logic        mul_guard, mul_sticky, mul_round;
    logic [9:0]  mul_man_r;
`else
    logic [10:0] mul_prod_hi;
`endif

    always_comb begin
        mul_res  = 16'h0000;
        mul_ma   = {1'b1, in_a_i[8:0]};
        mul_mb   = {1'b1, in_b_i[8:0]};
        mul_spec = (in_a_i[14:9] == 6'h3F) || (in_b_i[14:9] == 6'h3F);
        mul_zero = (in_a_i[14:9] == 6'h00) || (in_b_i[14:9] == 6'h00);
`ifdef DLMAC_ROUND_EN
        mul_prod    = {10'b0, mul_ma} * {10'b0, mul_mb};
        mul_norm    = mul_prod[19];
        mul_man     = mul_norm ? mul_prod[18:10] : mul_prod[17:9];
        mul_exp_sum = {3'b0, in_a_i[14:9]} + {3'b0, in_b_i[14:9]} + {8'b0, mul_norm};
        mul_guard   = mul_norm ? mul_prod[9] : mul_prod[8];
        mul_sticky  = mul_norm ? (|mul_prod[8:0]) : (|mul_prod[7:0]);
        mul_round   = mul_guard & (mul_sticky | mul_man[0]);
        mul_man_r   = {1'b0, mul_man} + {9'b0, mul_round};
        // Rounding carry-out: 1.111..1 + ulp becomes 10.0, so bump the exponent.
        if (mul_man_r[9]) begin
            mul_man     = 9'h000;
            mul_exp_sum = mul_exp_sum + 9'd1;
        end else begin
            mul_man = mul_man_r[8:0];
        end
`else
        // Only bits [19:9] of the product can reach a truncated mantissa.
        mul_prod_hi = 11'(({10'b0, mul_ma} * {10'b0, mul_mb}) >> 9);
        mul_norm    = mul_prod_hi[10];
        mul_man     = mul_norm ? mul_prod_hi[9:1] : mul_prod_hi[8:0];
        mul_exp_sum = {3'b0, in_a_i[14:9]} + {3'b0, in_b_i[14:9]} + {8'b0, mul_norm};
`endif
        // Special takes priority over zero, so NaN*0 stays NaN.
        if (mul_spec) begin
            mul_res = 16'hFFFF;
        end else if (mul_zero) begin
            mul_res = 16'h0000;
        end else if (mul_exp_sum > 9'd93) begin        // unbiased e > 62
            mul_res = 16'hFFFF;
        end else if (mul_exp_sum < 9'd32) begin        // unbiased e < 1
            mul_res = 16'h0000;
        end else begin
            mul_res = {in_a_i[15] ^ in_b_i[15], 6'(mul_exp_sum - 9'd31), mul_man};
        end
    end

    // ------------------------------------------------------------------
    // Adder: acc_q + prod_q, truncating alignment and normalisation
    // ------------------------------------------------------------------
    logic [15:0] add_res;
    logic        add_x_big;
    logic        add_sl, add_ss;
    logic [5:0]  add_el, add_es, add_ediff;
    logic [9:0]  add_ml, add_ms, add_ms_sh;
    logic [10:0] add_sum;
    logic [3:0]  add_lead;
    logic [8:0]  add_man;
    logic [7:0]  add_exp;       // larger exponent + leading-one position, offset by 9

    always_comb begin
        add_res   = acc_q;
        add_x_big = (acc_q[14:0] >= prod_q[14:0]);
        add_sl    = add_x_big ? acc_q[15]    : prod_q[15];
        add_ss    = add_x_big ? prod_q[15]   : acc_q[15];
        add_el    = add_x_big ? acc_q[14:9]  : prod_q[14:9];
        add_es    = add_x_big ? prod_q[14:9] : acc_q[14:9];
        add_ml    = add_x_big ? {1'b1, acc_q[8:0]}  : {1'b1, prod_q[8:0]};
        add_ms    = add_x_big ? {1'b1, prod_q[8:0]} : {1'b1, acc_q[8:0]};
        add_ediff = add_el - add_es;
        add_ms_sh = (add_ediff > 6'd9) ? 10'h000 : (add_ms >> add_ediff);
        // Larger magnitude is always the minuend, so the difference cannot go negative.
        if (add_sl == add_ss) begin
            add_sum = {1'b0, add_ml} + {1'b0, add_ms_sh};
        end else begin
            add_sum = {1'b0, add_ml} - {1'b0, add_ms_sh};
        end
        add_lead = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (add_sum[i]) begin
                add_lead = 4'(i);
            end
        end
        // Move the leading one to bit 10; the 9 bits below it are the mantissa.
        add_man = 9'((add_sum << (4'd10 - add_lead)) >> 1);
        add_exp = {2'b0, add_el} + {4'b0, add_lead};

        if ((acc_q[14:9] == 6'h3F) || (prod_q[14:9] == 6'h3F)) begin
            add_res = 16'hFFFF;
        end else if (acc_q[14:9] == 6'h00) begin
            add_res = prod_q;
        end else if (prod_q[14:9] == 6'h00) begin
            add_res = acc_q;
        end else if (add_sum == 11'h000) begin
            add_res = 16'h0000;
        end else if (add_exp > 8'd71) begin            // result exponent > 62
            add_res = 16'hFFFF;
        end else if (add_exp < 8'd10) begin            // result exponent < 1
            add_res = 16'h0000;
        end else begin
            add_res = {add_sl, 6'(add_exp - 8'd9), add_man};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_ACCUM;
            acc_q       <= 16'h0000;
            count_q     <= '0;
            prod_q      <= 16'h0000;
            prod_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        prod_d      = prod_q;
        prod_v_d    = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        in_ready_o  = 1'b0;

        // The product captured last cycle is folded in whatever the state.
        if (prod_v_q) begin
            acc_d = add_res;
        end

        case (state_q)
            ST_ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    prod_d   = mul_res;
                    prod_v_d = 1'b1;
                    count_d  = count_q + CNT_ONE;
                    if (in_last_i || (count_q == LAST_CNT)) begin
                        out_count_d = count_q + CNT_ONE;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                // First OUT cycle: accumulator is final, capture it into the output register.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                end else if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    acc_d       = 16'h0000;
                    count_d     = '0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;
    assign busy_o      = !((state_q == ST_ACCUM) && (count_q == '0));

endmodule

// File: tb/tb_dlfloat_vmac.sv
// Self-checking bench for dlfloat_vmac (VEC_LEN=4). Expected results are
// queued when a vector is driven and compared when the output transfers.

module tb_dlfloat_vmac;

    localparam int VEC_LEN = 4;
    localparam int CNT_W   = $clog2(VEC_LEN + 1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [15:0]      in_a_i;
    logic [15:0]      in_b_i;
    logic             in_last_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [15:0]      out_data_o;
    logic [CNT_W-1:0] out_count_o;
    logic             busy_o;

    typedef struct {
        logic [15:0] data;
        int          cnt;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dlfloat_vmac #(.VEC_LEN(VEC_LEN)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_count_o (out_count_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [15:0] data, input int cnt);
        exp_t e;
        e.data = data;
        e.cnt  = cnt;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Drives one beat and returns 1ns after the edge that accepted it.
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_a_i     = a;
        in_b_i     = b;
        in_last_i  = last;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) begin
            check_val("in_ready_timeout", 32'(in_ready_o), 32'd1);
            in_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic idle_in();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_val("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk_i) begin
        if (out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_out", 32'(out_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val({e.name, "_data"}, 32'(out_data_o), 32'(e.data));
                check_val({e.name, "_count"}, 32'(out_count_o), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_a_i      = 16'h0000;
        in_b_i      = 16'h0000;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        check_val("rst_in_ready",  32'(in_ready_o),  32'd1);
        check_val("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_val("rst_busy",      32'(busy_o),      32'd0);
        check_val("rst_out_data",  32'(out_data_o),  32'h0000);
        check_val("rst_out_count", 32'(out_count_o), 32'd0);

        // 1: four 1.0*1.0 products, full-length vector, latency
        push_exp("t1_sum4", 16'h4200, 4);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        check_val("t1_busy", 32'(busy_o), 32'd1);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        idle_in();
        @(posedge clk_i); #1;
        check_val("t1_valid_e1", 32'(out_valid_o), 32'd0);
        check_val("t1_ready_e1", 32'(in_ready_o),  32'd0);
        @(posedge clk_i); #1;
        check_val("t1_valid_e2", 32'(out_valid_o), 32'd1);
        wait_drain();

        // 2: 3.0 + 1.0 with early termination
        push_exp("t2_early", 16'h4200, 2);
        send_beat(16'h3F00, 16'h4000, 1'b0);
        send_beat(16'h3E00, 16'h3E00, 1'b1);
        idle_in();
        wait_drain();

        // 3: exact cancellation
        push_exp("t3_cancel", 16'h0000, 2);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        send_beat(16'hBE00, 16'h3E00, 1'b1);
        idle_in();
        wait_drain();

        // 4a: special operand is sticky
        push_exp("t4_sticky", 16'hFFFF, 4);
        send_beat(16'hFFFF, 16'h3E00, 1'b0);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        idle_in();
        wait_drain();

        // 4b: multiplier exponent overflow
        push_exp("t4_ovf", 16'hFFFF, 1);
        send_beat(16'h7C00, 16'h4000, 1'b1);
        idle_in();
        wait_drain();

        // Redundant in_last on the VEC_LEN-th beat: 4 x 2.0 = 8.0
        push_exp("last_on_full", 16'h4400, 4);
        send_beat(16'h4000, 16'h3E00, 1'b0);
        send_beat(16'h4000, 16'h3E00, 1'b0);
        send_beat(16'h4000, 16'h3E00, 1'b0);
        send_beat(16'h4000, 16'h3E00, 1'b1);
        idle_in();
        wait_drain();

        // 2.0 - 1.5 = 0.5: different exponents, left normalisation
        push_exp("sub_norm", 16'h3C00, 2);
        send_beat(16'h4000, 16'h3E00, 1'b0);
        send_beat(16'hBF00, 16'h3E00, 1'b1);
        idle_in();
        wait_drain();

        // 1.0 - 2.0 = -1.0: sign of the larger magnitude
        push_exp("neg_big", 16'hBE00, 2);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        send_beat(16'hC000, 16'h3E00, 1'b1);
        idle_in();
        wait_drain();

        // Mantissa truncation: 1.998*1.998 -> 0x41FE
        push_exp("trunc", 16'h41FE, 1);
        send_beat(16'h3FFF, 16'h3FFF, 1'b1);
        idle_in();
        wait_drain();

        // 5: output back-pressure
        out_ready_i = 1'b0;
        push_exp("t5_hold", 16'h4000, 2);
        send_beat(16'h3E00, 16'h3E00, 1'b0);
        send_beat(16'h3E00, 16'h3E00, 1'b1);
        idle_in();
        begin
            int n;
            n = 0;
            while (!out_valid_o && n < 20) begin
                @(negedge clk_i);
                n++;
            end
            check_val("t5_valid_seen", 32'(out_valid_o), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_val("t5_hold_valid", 32'(out_valid_o), 32'd1);
            check_val("t5_hold_data",  32'(out_data_o),  32'h4000);
            check_val("t5_hold_count", 32'(out_count_o), 32'd2);
            check_val("t5_hold_ready", 32'(in_ready_o),  32'd0);
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check_val("t5_ready_after", 32'(in_ready_o), 32'd1);
        push_exp("t5_next", 16'h3E00, 1);
        send_beat(16'h3E00, 16'h3E00, 1'b1);
        idle_in();
        wait_drain();

        // 6: reset mid-vector discards partial state
        send_beat(16'h4000, 16'h4000, 1'b0);
        send_beat(16'h4000, 16'h4000, 1'b0);
        idle_in();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("t6_busy",      32'(busy_o),      32'd0);
        check_val("t6_out_count", 32'(out_count_o), 32'd0);
        push_exp("t6_after_rst", 16'h4000, 1);
        send_beat(16'h4000, 16'h3E00, 1'b1);
        idle_in();
        wait_drain();

        repeat (3) @(negedge clk_i);
        check_val("no_extra_out", 32'(out_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
